// File: rtl/up_counter_mod_load.sv
// Modulo-MOD up counter with parallel load, count enable, synchronous clear,
// combinational terminal count, registered wrap pulse and a sticky load-error flag.
module up_counter_mod_load #(
    parameter int WIDTH = 3,
    parameter int MOD   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    // Priority: clear > load > en > hold.
    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (clear) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (load) begin
            // Zero-extended compare keeps MOD == 2**WIDTH representable.
            if ({1'b0, load_val} < MOD_EXT) begin
                count_d = load_val;
            end else begin
                count_d = '0;
                err_d   = 1'b1;
            end
        end else if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign q        = count_q;
    assign tc       = en & (count_q == LAST);
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule
